// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch address generation and the IF/ID
// pipeline register with freeze/flush/branch control and a fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  logic [31:0] pc_q, pc_d, pc_next;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        load;

  assign pc_next = pc_q + 32'd4;

  // Branch beats freeze so a redirect is never lost behind a stall.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken)  pc_d = {branch_addr[31:2], 2'b00};
    else if (!freeze)  pc_d = pc_next;
  end

  // Flush beats freeze; branch alone leaves IF/ID untouched.
  always_comb begin
    ifid_d = ifid_q;
    load   = 1'b0;
    if (flush) begin
      ifid_d = '0;
    end else if (!freeze) begin
      ifid_d = '{pc: pc_next, instr: imem_instruction, valid: 1'b1};
      load   = 1'b1;
    end
    cnt_d = cnt_q + {31'd0, load};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ifid_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign imem_addr       = pc_q;
  assign pc_out          = ifid_q.pc;
  assign instruction_out = ifid_q.instr;
  assign valid_out       = ifid_q.valid;
  assign fetch_count     = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory model returns the address as the word.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, flush;
  logic [31:0] branch_addr;
  logic [31:0] a_addr, a_pc, a_instr, a_cnt;
  logic        a_vld;
  logic [31:0] b_addr, b_pc, b_instr, b_cnt;
  logic        b_vld;
  logic [31:0] a_mem, b_mem;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign a_mem = a_addr;
  assign b_mem = b_addr;

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .flush(flush), .imem_addr(a_addr),
    .imem_instruction(a_mem), .pc_out(a_pc), .instruction_out(a_instr),
    .valid_out(a_vld), .fetch_count(a_cnt));

  if_stage #(.RESET_PC(32'h10)) dut_rp (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .flush(flush), .imem_addr(b_addr),
    .imem_instruction(b_mem), .pc_out(b_pc), .instruction_out(b_instr),
    .valid_out(b_vld), .fetch_count(b_cnt));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic r, input logic fz, input logic br,
                       input logic [31:0] ba, input logic fl);
    rst = r; freeze = fz; branch_taken = br; branch_addr = ba; flush = fl;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 32'h55, 0);
    step(); step();
    checks++; if (a_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", a_addr, 32'h0); end
    checks++; if ({a_pc, a_instr, a_cnt, a_vld} !== 97'd0) begin failures++; $display("FAIL reset_outs got=%h/%h/%h/%b exp=0", a_pc, a_instr, a_cnt, a_vld); end
    checks++; if (b_addr !== 32'h10) begin failures++; $display("FAIL reset_pc_param got=%h exp=%h", b_addr, 32'h10); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_addr [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] exp_pc   [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] exp_ins  [3] = '{32'h0, 32'h4, 32'h8};
    drive(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (a_addr !== exp_addr[i]) begin failures++; $display("FAIL run_addr[%0d] got=%h exp=%h", i, a_addr, exp_addr[i]); end
      checks++; if (a_pc !== exp_pc[i] || a_instr !== exp_ins[i] || a_vld !== 1'b1) begin failures++; $display("FAIL run_ifid[%0d] got=%h/%h/%b exp=%h/%h/1", i, a_pc, a_instr, a_vld, exp_pc[i], exp_ins[i]); end
    end
    checks++; if (a_cnt !== 32'd3) begin failures++; $display("FAIL run_count got=%0d exp=3", a_cnt); end
  endtask

  task automatic test_freeze();
    drive(0, 0, 1, 32'h8, 0);   // redirect to 8; IF/ID still loads 12's word
    step();
    checks++; if (a_addr !== 32'h8 || a_pc !== 32'h10 || a_instr !== 32'hC || a_cnt !== 32'd4) begin failures++; $display("FAIL pre_freeze got=%h/%h/%h/%0d exp=8/10/c/4", a_addr, a_pc, a_instr, a_cnt); end
    drive(0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (a_addr !== 32'h8 || a_pc !== 32'h10 || a_instr !== 32'hC || a_cnt !== 32'd4 || a_vld !== 1'b1) begin failures++; $display("FAIL freeze_hold[%0d] got=%h/%h/%h/%0d exp=8/10/c/4", i, a_addr, a_pc, a_instr, a_cnt); end
    end
    drive(0, 0, 0, 32'h0, 0);
    step();
    checks++; if (a_addr !== 32'hC || a_pc !== 32'hC || a_instr !== 32'h8 || a_cnt !== 32'd5) begin failures++; $display("FAIL freeze_release got=%h/%h/%h/%0d exp=c/c/8/5", a_addr, a_pc, a_instr, a_cnt); end
  endtask

  task automatic test_branch_flush();
    step(); step();
    checks++; if (a_addr !== 32'h14 || a_cnt !== 32'd7) begin failures++; $display("FAIL reach_pc20 got=%h/%0d exp=14/7", a_addr, a_cnt); end
    drive(0, 1, 1, 32'h43, 1);
    step();
    checks++; if (a_addr !== 32'h40) begin failures++; $display("FAIL branch_addr got=%h exp=%h", a_addr, 32'h40); end
    checks++; if (a_vld !== 1'b0 || a_instr !== 32'h0 || a_pc !== 32'h0 || a_cnt !== 32'd7) begin failures++; $display("FAIL branch_flush got=%b/%h/%h/%0d exp=0/0/0/7", a_vld, a_instr, a_pc, a_cnt); end
  endtask

  task automatic test_wrap();
    drive(0, 0, 1, 32'hFFFF_FFFE, 0);
    step();
    checks++; if (a_addr !== 32'hFFFF_FFFC || a_pc !== 32'h44 || a_cnt !== 32'd8) begin failures++; $display("FAIL wrap_setup got=%h/%h/%0d exp=fffffffc/44/8", a_addr, a_pc, a_cnt); end
    drive(0, 0, 0, 32'h0, 0);
    step();
    checks++; if (a_addr !== 32'h0 || a_pc !== 32'h0 || a_instr !== 32'hFFFF_FFFC || a_vld !== 1'b1) begin failures++; $display("FAIL wrap got=%h/%h/%h/%b exp=0/0/fffffffc/1", a_addr, a_pc, a_instr, a_vld); end
  endtask

  task automatic test_flush_only();
    drive(0, 0, 1, 32'h18, 0);
    step();
    checks++; if (a_addr !== 32'h18 || a_cnt !== 32'd10) begin failures++; $display("FAIL reach_pc24 got=%h/%0d exp=18/10", a_addr, a_cnt); end
    drive(0, 0, 0, 32'h0, 1);
    step();
    checks++; if (a_vld !== 1'b0 || a_addr !== 32'h1C || a_cnt !== 32'd10 || a_pc !== 32'h0) begin failures++; $display("FAIL flush_only got=%b/%h/%0d/%h exp=0/1c/10/0", a_vld, a_addr, a_cnt, a_pc); end
  endtask

  task automatic test_reset_branch();
    drive(1, 1, 1, 32'h100, 0);
    step();
    checks++; if (b_addr !== 32'h10 || {b_pc, b_instr, b_cnt, b_vld} !== 97'd0) begin failures++; $display("FAIL rst_branch got=%h/%h/%h/%h/%b exp=10/0/0/0/0", b_addr, b_pc, b_instr, b_cnt, b_vld); end
    drive(0, 0, 0, 32'h0, 0);
    checks++; if (b_addr !== 32'h10) begin failures++; $display("FAIL rst_release0 got=%h exp=10", b_addr); end
    step();
    checks++; if (b_addr !== 32'h14 || b_pc !== 32'h14 || b_instr !== 32'h10 || b_vld !== 1'b1 || b_cnt !== 32'd1) begin failures++; $display("FAIL rst_release1 got=%h/%h/%h/%b/%0d exp=14/14/10/1/1", b_addr, b_pc, b_instr, b_vld, b_cnt); end
  endtask

  initial begin
    drive(1, 0, 0, 32'h0, 0);
    test_reset();
    test_free_run();
    test_freeze();
    test_branch_flush();
    test_wrap();
    test_flush_only();
    test_reset_branch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'd0, the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port freeze, input, 1 bit: hazard stall; holds the PC and the IF/ID register.
REQ-005 The block SHALL have port branch_taken, input, 1 bit: redirects the PC to branch_addr.
REQ-006 The block SHALL have port branch_addr, input, 32 bits: branch target byte address.
REQ-007 The block SHALL have port flush, input, 1 bit: invalidates the IF/ID register contents.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: fetch address driven to the instruction memory.
REQ-009 The block SHALL have port imem_instruction, input, 32 bits: instruction word returned combinationally by the instruction memory.
REQ-010 The block SHALL have port pc_out, output, 32 bits: registered PC+4 of the fetched instruction.
REQ-011 The block SHALL have port instruction_out, output, 32 bits: registered fetched instruction.
REQ-012 The block SHALL have port valid_out, output, 1 bit: IF/ID register holds a real instruction.
REQ-013 The block SHALL have port fetch_count, output, 32 bits: count of instructions accepted into IF/ID.

Function
REQ-014 The block SHALL keep an internal 32-bit PC register, and imem_addr SHALL equal PC combinationally, with zero-cycle latency.
REQ-015 The block SHALL compute pc_next as PC+4, modulo 2^32; 32'hFFFFFFFC SHALL wrap to 32'h00000000.
REQ-016 On each edge without rst, the PC SHALL update with this priority: branch_taken loads {branch_addr[31:2],2'b00}; otherwise freeze holds the PC; otherwise the PC loads pc_next.
REQ-017 When branch_taken and freeze are high together, branch_taken SHALL win.
REQ-018 On each edge without rst, the IF/ID register SHALL update with this priority: flush clears it (pc_out=0, instruction_out=0, valid_out=0); otherwise freeze holds it; otherwise it loads pc_out=pc_next, instruction_out=imem_instruction, valid_out=1.
REQ-019 When flush and freeze are high together, flush SHALL win.
REQ-020 branch_taken SHALL NOT by itself clear the IF/ID register; the controller SHALL assert flush in the same cycle.
REQ-021 fetch_count SHALL increment by 1 on each edge where the IF/ID register loads (no rst, no flush, no freeze), and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-022 Latency SHALL be one cycle: the instruction at address A appears on instruction_out on the edge after imem_addr=A, provided no freeze and no flush.
REQ-023 The block SHALL contain no combinational path from imem_instruction to any output.

Reset
REQ-024 While rst is high at an edge, the block SHALL set PC=RESET_PC, pc_out=0, instruction_out=0, valid_out=0, and fetch_count=0, regardless of all other inputs.
REQ-025 Reset asserted mid-stall or mid-branch SHALL discard the pending redirect; the first edge after rst falls SHALL fetch from RESET_PC.
REQ-026 imem_addr SHALL equal RESET_PC in the cycle after the reset edge.

Verification
REQ-027 The bench SHALL cover: rst for 2 cycles, then 3 free-running cycles with the memory returning word A at address A -> imem_addr 0,4,8,12; pc_out 4,8,12; valid_out=1; fetch_count=3.
REQ-028 The bench SHALL cover: freeze=1 for 2 cycles while PC=8 -> imem_addr stays 8; pc_out and instruction_out hold their prior values; fetch_count unchanged; PC=12 after freeze drops.
REQ-029 The bench SHALL cover: branch_taken=1, branch_addr=32'h00000043, flush=1, freeze=1, all at PC=20 -> next imem_addr=32'h40; valid_out=0; instruction_out=0; fetch_count unchanged.
REQ-030 The bench SHALL cover: PC forced to 32'hFFFFFFFC by branch -> next fetch loads pc_out=0 and imem_addr=0.
REQ-031 The bench SHALL cover: rst asserted together with branch_taken=1 and branch_addr=32'h100, with RESET_PC=32'h10 -> PC=32'h10, all outputs zero; after release imem_addr sequence is 0x10, 0x14.
REQ-032 The bench SHALL cover: flush=1 alone at PC=24 -> valid_out=0 and PC advances to 28.
